wb_dcache_victim_ctrl: RTL and testbench
========================================

WB_DCACHE_VICTIM_CTRL -- requirements
Module: wb_dcache_victim_ctrl

Interface
REQ-001 SHALL have parameter DCACHE_IDX_BITS, default 7, set-index width (128 sets).
REQ-002 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports lsummu2dcache_req_i / lsummu2dcache_wr_i  in  1 each  LSU request / write (1) vs read (0); held until ack.
REQ-005 SHALL have port dcache_flush_i  in  1  flush request; held until flush ack.
REQ-006 SHALL have ports dcache2lsummu_ack_o / dcache_flush_ack_o  out  1 each  request done / flush done.
REQ-007 SHALL have ports cache_hit_i, cache_evict_req_i (line dirty), v_hit_i  in  1 each  datapath/victim status, valid one cycle after RAM read.
REQ-008 SHALL have ports cache_wr_o, cache_line_wr_o, cache_line_clean_o, cache_wrb_req_o, v_wr_en_o, wr_from_victim_o, flush_active_o  out  1 each  datapath controls.
REQ-009 SHALL have port evict_index_o  out  DCACHE_IDX_BITS  flush set index.
REQ-010 SHALL have ports dcache2mem_req_o / dcache2mem_wr_o  out  1 each, mem2dcache_ack_i  in  1  memory handshake.

Function
REQ-011 SHALL implement states IDLE, LOOKUP, VSWAP, WRB, ALLOC, FL_READ, FL_CHECK, FL_WRB, FL_DONE.
REQ-012 IDLE: flush_i -> FL_READ with index 0 (flush wins if simultaneous with req); else req_i -> LOOKUP.
REQ-013 LOOKUP (RAM read 1 cycle earlier): hit & read -> ack_o pulse 1 cycle -> IDLE; hit & write -> cache_wr_o and ack_o 1 cycle -> IDLE; read-hit latency 2 cycles from req.
REQ-014 LOOKUP miss & v_hit_i -> VSWAP: one cycle wr_from_victim_o=cache_line_wr_o=v_wr_en_o=1 (line swap), then LOOKUP replay.
REQ-015 LOOKUP miss & !v_hit & dirty -> WRB; miss & !v_hit & clean -> v_wr_en_o pulse 1 cycle, then ALLOC.
REQ-016 WRB: dcache2mem_req_o=1, wr_o=1, cache_wrb_req_o=1 until ack_i; in ack cycle v_wr_en_o=1; next state ALLOC.
REQ-017 ALLOC: dcache2mem_req_o=1, wr_o=0 until ack_i; in ack cycle cache_line_wr_o=1; next state LOOKUP replay (guaranteed hit).
REQ-018 Memory handshake: req asserted from state entry, ack accepted in any cycle incl. first, req drops the cycle after ack; ack outside WRB/ALLOC/FL_WRB ignored.
REQ-019 flush_active_o SHALL be 1 in all FL_* states, 0 otherwise; evict_index_o driven from an internal counter.
REQ-020 FL_READ: one-cycle tag read -> FL_CHECK; dirty -> FL_WRB, else advance.
REQ-021 FL_WRB: mem req/wr and cache_wrb_req_o until ack; ack cycle cache_line_clean_o=1; then advance.
REQ-022 Advance: counter < 2^DCACHE_IDX_BITS-1 -> increment, FL_READ; at last index -> FL_DONE (no wrap).
REQ-023 FL_DONE: dcache_flush_ack_o pulse 1 cycle, counter to 0 -> IDLE; LSU requests wait until IDLE.
REQ-024 All one-cycle controls SHALL be registered-state decodes, never asserted simultaneously with a conflicting write (cache_wr_o and cache_line_wr_o mutually exclusive).

Reset
REQ-025 rst_n=0 SHALL force IDLE, counter 0, every output 0 next edge, including mid-WRB/ALLOC/flush (outstanding memory request abandoned).
REQ-026 After reset release SHALL accept a request the first cycle rst_n=1.

Verification
REQ-027 Read hit: req, rd, hit=1 -> ack_o at cycle 2, no mem req, no v_wr_en.
REQ-028 Write miss, victim hit: hit=0, v_hit=1 -> VSWAP cycle with 3 strobes, replay hit, cache_wr_o+ack 1 cycle.
REQ-029 Read miss dirty, victim miss, ack delays 3 and 2 cycles -> WRB req wr=1 4 cycles, v_wr_en at ack, ALLOC req wr=0 3 cycles, cache_line_wr_o, ack_o.
REQ-030 Flush IDX_BITS=2, sets 1 and 3 dirty -> evict_index 0..3, two writebacks each followed by clean, flush_ack_o once, flush_active_o low after.
REQ-031 Flush and req same cycle -> flush completes first; req acked after.
REQ-032 rst_n low during ALLOC with req pending -> next cycle all outputs 0, state IDLE; late ack ignored.

Source files
------------

// File: rtl/wb_dcache_victim_ctrl.sv
// wb_dcache_victim_ctrl
// Control FSM for a write-back data cache backed by a victim buffer.
// It serves LSU read and write requests, swaps lines with the victim buffer,
// writes back dirty lines and refills from memory. It also walks every set
// on a flush request.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   lsummu2dcache_req_i/_wr_i      LSU request and direction, held until ack
//   dcache_flush_i                 flush request, held until flush ack
//   dcache2lsummu_ack_o            LSU request done (1-cycle pulse)
//   dcache_flush_ack_o             flush done (1-cycle pulse)
//   cache_hit_i, cache_evict_req_i, v_hit_i
//                                  datapath status, valid one cycle after the RAM read
//   cache_wr_o                     write LSU data into a hit line
//   cache_line_wr_o                write a whole line (refill or victim swap)
//   cache_line_clean_o             clear the dirty bit of the flushed line
//   cache_wrb_req_o                a writeback is in progress
//   v_wr_en_o                      write the evicted line into the victim buffer
//   wr_from_victim_o               line source is the victim buffer
//   flush_active_o                 flush walk in progress
//   evict_index_o                  set index being flushed
//   dcache2mem_req_o/_wr_o, mem2dcache_ack_i
//                                  memory handshake
// Every output comes directly from a flop.
module wb_dcache_victim_ctrl #(
    parameter int DCACHE_IDX_BITS = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lsummu2dcache_req_i,
    input  logic                       lsummu2dcache_wr_i,
    input  logic                       dcache_flush_i,
    output logic                       dcache2lsummu_ack_o,
    output logic                       dcache_flush_ack_o,
    input  logic                       cache_hit_i,
    input  logic                       cache_evict_req_i,
    input  logic                       v_hit_i,
    output logic                       cache_wr_o,
    output logic                       cache_line_wr_o,
    output logic                       cache_line_clean_o,
    output logic                       cache_wrb_req_o,
    output logic                       v_wr_en_o,
    output logic                       wr_from_victim_o,
    output logic                       flush_active_o,
    output logic [DCACHE_IDX_BITS-1:0] evict_index_o,
    output logic                       dcache2mem_req_o,
    output logic                       dcache2mem_wr_o,
    input  logic                       mem2dcache_ack_i
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOOKUP   = 4'd1,
        S_VSWAP    = 4'd2,
        S_WRB      = 4'd3,
        S_ALLOC    = 4'd4,
        S_FL_READ  = 4'd5,
        S_FL_CHECK = 4'd6,
        S_FL_WRB   = 4'd7,
        S_FL_DONE  = 4'd8
    } state_t;

    localparam logic [DCACHE_IDX_BITS-1:0] LAST_IDX = {DCACHE_IDX_BITS{1'b1}};

    state_t                     r_state;
    logic [DCACHE_IDX_BITS-1:0] r_idx;
    logic r_ack, r_flush_ack, r_cache_wr, r_line_wr, r_line_clean, r_wrb_req;
    logic r_v_wr_en, r_from_victim, r_flush_active, r_mem_req, r_mem_wr;

    // Accept an ack only while a request is actually outstanding. This drops
    // stray acks, acks during the post-ack strobe cycle, and late acks after reset.
    logic w_mem_ack;
    logic w_last;
    assign w_mem_ack = mem2dcache_ack_i & r_mem_req;
    assign w_last    = (r_idx == LAST_IDX);

    // Main FSM: state, flush counter and every output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_ack          <= 1'b0;
            r_flush_ack    <= 1'b0;
            r_cache_wr     <= 1'b0;
            r_line_wr      <= 1'b0;
            r_line_clean   <= 1'b0;
            r_wrb_req      <= 1'b0;
            r_v_wr_en      <= 1'b0;
            r_from_victim  <= 1'b0;
            r_flush_active <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_wr       <= 1'b0;
        end else begin
            // One-cycle strobes fall back to 0 unless a branch re-asserts them.
            r_ack         <= 1'b0;
            r_flush_ack   <= 1'b0;
            r_cache_wr    <= 1'b0;
            r_line_wr     <= 1'b0;
            r_line_clean  <= 1'b0;
            r_v_wr_en     <= 1'b0;
            r_from_victim <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Flush has priority. While the ack pulse is high, the LSU
                    // still holds the request it just completed, so ignore it.
                    if (dcache_flush_i) begin
                        r_state        <= S_FL_READ;
                        r_idx          <= '0;
                        r_flush_active <= 1'b1;
                    end else if (lsummu2dcache_req_i && !r_ack) begin
                        r_state <= S_LOOKUP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit_i) begin
                        r_ack      <= 1'b1;
                        r_cache_wr <= lsummu2dcache_wr_i;
                        r_state    <= S_IDLE;
                    end else if (v_hit_i) begin
                        r_from_victim <= 1'b1;
                        r_line_wr     <= 1'b1;
                        r_v_wr_en     <= 1'b1;
                        r_state       <= S_VSWAP;
                    end else if (cache_evict_req_i) begin
                        r_mem_req <= 1'b1;
                        r_mem_wr  <= 1'b1;
                        r_wrb_req <= 1'b1;
                        r_state   <= S_WRB;
                    end else begin
                        // The clean line goes to the victim buffer as the refill starts.
                        r_v_wr_en <= 1'b1;
                        r_mem_req <= 1'b1;
                        r_mem_wr  <= 1'b0;
                        r_state   <= S_ALLOC;
                    end
                end
                S_VSWAP: begin
                    r_state <= S_LOOKUP;
                end
                S_WRB: begin
                    // r_v_wr_en marks the cycle after the ack, when the request has dropped.
                    if (r_v_wr_en) begin
                        r_mem_req <= 1'b1;
                        r_mem_wr  <= 1'b0;
                        r_state   <= S_ALLOC;
                    end else if (w_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_wr  <= 1'b0;
                        r_wrb_req <= 1'b0;
                        r_v_wr_en <= 1'b1;
                    end else begin
                        r_state <= S_WRB;
                    end
                end
                S_ALLOC: begin
                    if (r_line_wr) begin
                        r_state <= S_LOOKUP;
                    end else if (w_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_line_wr <= 1'b1;
                    end else begin
                        r_state <= S_ALLOC;
                    end
                end
                S_FL_READ: begin
                    r_state <= S_FL_CHECK;
                end
                S_FL_CHECK: begin
                    if (cache_evict_req_i) begin
                        r_mem_req <= 1'b1;
                        r_mem_wr  <= 1'b1;
                        r_wrb_req <= 1'b1;
                        r_state   <= S_FL_WRB;
                    end else if (w_last) begin
                        r_flush_ack <= 1'b1;
                        r_state     <= S_FL_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_FL_READ;
                    end
                end
                S_FL_WRB: begin
                    // After the clean strobe, advance exactly like a clean set.
                    if (r_line_clean) begin
                        if (w_last) begin
                            r_flush_ack <= 1'b1;
                            r_state     <= S_FL_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_FL_READ;
                        end
                    end else if (w_mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_mem_wr     <= 1'b0;
                        r_wrb_req    <= 1'b0;
                        r_line_clean <= 1'b1;
                    end else begin
                        r_state <= S_FL_WRB;
                    end
                end
                S_FL_DONE: begin
                    r_idx          <= '0;
                    r_flush_active <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_idx          <= '0;
                    r_wrb_req      <= 1'b0;
                    r_flush_active <= 1'b0;
                    r_mem_req      <= 1'b0;
                    r_mem_wr       <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign dcache2lsummu_ack_o = r_ack;
    assign dcache_flush_ack_o  = r_flush_ack;
    assign cache_wr_o          = r_cache_wr;
    assign cache_line_wr_o     = r_line_wr;
    assign cache_line_clean_o  = r_line_clean;
    assign cache_wrb_req_o     = r_wrb_req;
    assign v_wr_en_o           = r_v_wr_en;
    assign wr_from_victim_o    = r_from_victim;
    assign flush_active_o      = r_flush_active;
    assign evict_index_o       = r_idx;
    assign dcache2mem_req_o    = r_mem_req;
    assign dcache2mem_wr_o     = r_mem_wr;

endmodule

// File: tb/tb_wb_dcache_victim_ctrl.sv
// Testbench for wb_dcache_victim_ctrl with a 2-bit set index.
// A per-cycle vector table drives the inputs and gives the expected outputs.
// A scoreboard queue holds the expected order of LSU and flush acks.
// A hand-written sequence covers refills with random memory latency.
module tb_wb_dcache_victim_ctrl;

    localparam int IDXB = 2;

    // Output vector bit positions: {ack, fack, cwr, lwr, lcl, wrb, vwr, fv, fa, mreq, mwr}
    localparam logic [10:0] NONE = 11'h000, ACK = 11'h400, FACK = 11'h200, CWR = 11'h100;
    localparam logic [10:0] LWR  = 11'h080, LCL = 11'h040, WRB  = 11'h020, VWR = 11'h010;
    localparam logic [10:0] FV   = 11'h008, FA  = 11'h004, MRQ  = 11'h002, MWR = 11'h001;

    logic clk = 1'b0;
    logic rst_n, req, wr, flush, hit, evict, vhit, mack;
    logic ack, fack, cwr, lwr, lcl, wrb, vwr, fv, fa, mreq, mwr;
    logic [IDXB-1:0] idx;
    logic [10:0] outs;

    assign outs = {ack, fack, cwr, lwr, lcl, wrb, vwr, fv, fa, mreq, mwr};

    always #5 clk = ~clk;

    wb_dcache_victim_ctrl #(.DCACHE_IDX_BITS(IDXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsummu2dcache_req_i(req), .lsummu2dcache_wr_i(wr), .dcache_flush_i(flush),
        .dcache2lsummu_ack_o(ack), .dcache_flush_ack_o(fack),
        .cache_hit_i(hit), .cache_evict_req_i(evict), .v_hit_i(vhit),
        .cache_wr_o(cwr), .cache_line_wr_o(lwr), .cache_line_clean_o(lcl),
        .cache_wrb_req_o(wrb), .v_wr_en_o(vwr), .wr_from_victim_o(fv),
        .flush_active_o(fa), .evict_index_o(idx),
        .dcache2mem_req_o(mreq), .dcache2mem_wr_o(mwr), .mem2dcache_ack_i(mack)
    );

    typedef struct {
        string       nm;
        logic        rn, rq, w, fl, h, ev, vh, ma;
        logic [10:0] e;
        logic [1:0]  ix;
        int          p;   // 0 none, 1 expect LSU ack, 2 expect flush ack, 3 flush then LSU
    } row_t;

    row_t rows[$];
    int   sb[$];          // expected ack order: 1 = LSU ack, 2 = flush ack
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input string nm, input logic rn, rq, w, fl, h, ev, vh, ma,
                       input logic [10:0] e, input logic [1:0] ix, input int p);
        row_t r;
        r.nm = nm; r.rn = rn; r.rq = rq; r.w = w; r.fl = fl; r.h = h;
        r.ev = ev; r.vh = vh; r.ma = ma; r.e = e; r.ix = ix; r.p = p;
        rows.push_back(r);
    endtask

    // Scoreboard monitor: every ack pulse must match the head of the queue.
    always @(negedge clk) begin
        int k;
        if (ack === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_lsu_ack: got unexpected LSU ack, required none");
            end else begin
                k = sb.pop_front();
                if (k != 1) begin
                    n_fail++;
                    $display("FAIL sb_lsu_ack: got LSU ack, required ack kind %0d", k);
                end
            end
        end
        if (fack === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_flush_ack: got unexpected flush ack, required none");
            end else begin
                k = sb.pop_front();
                if (k != 2) begin
                    n_fail++;
                    $display("FAIL sb_flush_ack: got flush ack, required ack kind %0d", k);
                end
            end
        end
    end

    task automatic drive(input logic rq, w, fl, h, ev, vh, ma);
        req = rq; wr = w; flush = fl; hit = h; evict = ev; vhit = vh; mack = ma;
    endtask

    // Refill after a clean miss with memory latency d. Check the request
    // length and that the LSU ack arrives within a bounded number of cycles.
    task automatic rand_miss(input int d);
        int  cnt;
        bit  got;
        cnt = 0;
        got = 1'b0;
        @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 0); sb.push_back(1);
        @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k <= d; k++) begin
            @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, (k == d) ? 1'b1 : 1'b0);
            @(negedge clk);
            if (mreq) cnt++;
        end
        @(posedge clk); #1; drive(1, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL rand_miss_ack: no LSU ack within 10 cycles, required one (delay %0d)", d);
        end
        n_tests++;
        if (cnt != d + 1) begin
            n_fail++;
            $display("FAIL rand_miss_reqlen: mem req %0d cycles, required %0d", cnt, d + 1);
        end
        @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //   name      rn rq w  fl h  ev vh ma  expected           idx  sb
        add("reset",   0, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        // read hit, issued in the first cycle after reset release
        add("rd_hit",  1, 1, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 1);
        add("rd_hit",  1, 1, 0, 0, 1, 0, 0, 0, NONE,             2'd0, 0);
        add("rd_hit",  1, 1, 0, 0, 0, 0, 0, 0, ACK,              2'd0, 0);
        add("rd_hit",  1, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        // write hit
        add("wr_hit",  1, 1, 1, 0, 0, 0, 0, 0, NONE,             2'd0, 1);
        add("wr_hit",  1, 1, 1, 0, 1, 0, 0, 0, NONE,             2'd0, 0);
        add("wr_hit",  1, 1, 1, 0, 0, 0, 0, 0, ACK | CWR,        2'd0, 0);
        add("wr_hit",  1, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        // write miss, victim hit: swap, then replay hit
        add("vswap",   1, 1, 1, 0, 0, 0, 0, 0, NONE,             2'd0, 1);
        add("vswap",   1, 1, 1, 0, 0, 0, 1, 0, NONE,             2'd0, 0);
        add("vswap",   1, 1, 1, 0, 0, 0, 0, 0, LWR | VWR | FV,   2'd0, 0);
        add("vswap",   1, 1, 1, 0, 1, 0, 0, 0, NONE,             2'd0, 0);
        add("vswap",   1, 1, 1, 0, 0, 0, 0, 0, ACK | CWR,        2'd0, 0);
        add("vswap",   1, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        // read miss, clean line, ack in the first ALLOC cycle
        add("clean",   1, 1, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 1);
        add("clean",   1, 1, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        add("clean",   1, 1, 0, 0, 0, 0, 0, 1, VWR | MRQ,        2'd0, 0);
        add("clean",   1, 1, 0, 0, 0, 0, 0, 0, LWR,              2'd0, 0);
        add("clean",   1, 1, 0, 0, 1, 0, 0, 0, NONE,             2'd0, 0);
        add("clean",   1, 1, 0, 0, 0, 0, 0, 0, ACK,              2'd0, 0);
        add("clean",   1, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        // read miss, dirty line: writeback ack delay 3, refill ack delay 2, stray acks ignored
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 1);
        add("dirty",   1, 1, 0, 0, 0, 1, 0, 0, NONE,             2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 0, MRQ | MWR | WRB,  2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 0, MRQ | MWR | WRB,  2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 0, MRQ | MWR | WRB,  2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 1, MRQ | MWR | WRB,  2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 1, VWR,              2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 0, MRQ,              2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 0, MRQ,              2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 1, MRQ,              2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 1, LWR,              2'd0, 0);
        add("dirty",   1, 1, 0, 0, 1, 0, 0, 1, NONE,             2'd0, 0);
        add("dirty",   1, 1, 0, 0, 0, 0, 0, 0, ACK,              2'd0, 0);
        add("dirty",   1, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        // flush and read request in the same cycle; sets 1 and 3 dirty
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, NONE,             2'd0, 3);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA,               2'd0, 0);
        add("flush",   1, 1, 0, 1, 1, 0, 0, 0, FA,               2'd0, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA,               2'd1, 0);
        add("flush",   1, 1, 0, 1, 0, 1, 0, 0, FA,               2'd1, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 1, FA | MRQ | MWR | WRB, 2'd1, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA | LCL,         2'd1, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA,               2'd2, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA,               2'd2, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA,               2'd3, 0);
        add("flush",   1, 1, 0, 1, 0, 1, 0, 0, FA,               2'd3, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA | MRQ | MWR | WRB, 2'd3, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 1, FA | MRQ | MWR | WRB, 2'd3, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA | LCL,         2'd3, 0);
        add("flush",   1, 1, 0, 1, 0, 0, 0, 0, FA | FACK,        2'd3, 0);
        add("fl_req",  1, 1, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        add("fl_req",  1, 1, 0, 0, 1, 0, 0, 0, NONE,             2'd0, 0);
        add("fl_req",  1, 1, 0, 0, 0, 0, 0, 0, ACK,              2'd0, 0);
        add("fl_req",  1, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        // reset during ALLOC, late ack ignored, request taken right after release
        add("rst_al",  1, 1, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        add("rst_al",  1, 1, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);
        add("rst_al",  1, 1, 0, 0, 0, 0, 0, 0, VWR | MRQ,        2'd0, 0);
        add("rst_al",  0, 1, 0, 0, 0, 0, 0, 0, MRQ,              2'd0, 0);
        add("rst_al",  1, 1, 0, 0, 0, 0, 0, 1, NONE,             2'd0, 1);
        add("rst_al",  1, 1, 0, 0, 1, 0, 0, 1, NONE,             2'd0, 0);
        add("rst_al",  1, 1, 0, 0, 0, 0, 0, 0, ACK,              2'd0, 0);
        add("rst_al",  1, 0, 0, 0, 0, 0, 0, 0, NONE,             2'd0, 0);

        for (int i = 0; i < rows.size(); i++) begin
            @(posedge clk); #1;
            rst_n = rows[i].rn;
            drive(rows[i].rq, rows[i].w, rows[i].fl, rows[i].h, rows[i].ev, rows[i].vh, rows[i].ma);
            if (rows[i].p == 1) sb.push_back(1);
            if (rows[i].p == 2) sb.push_back(2);
            if (rows[i].p == 3) begin
                sb.push_back(2);
                sb.push_back(1);
            end
            @(negedge clk);
            n_tests++;
            if ({outs, idx} !== {rows[i].e, rows[i].ix}) begin
                n_fail++;
                $display("FAIL row %0d %s: got outs %b idx %0d, required outs %b idx %0d",
                         i, rows[i].nm, outs, idx, rows[i].e, rows[i].ix);
            end
        end

        rand_miss(0);
        for (int j = 0; j < 3; j++) begin
            rand_miss(int'($urandom_range(4, 0)));
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d acks still expected, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
